nv_blkbox_sink_mon: RTL and testbench
=====================================

Name: nv_blkbox_sink_mon

Overview:
- Receiving end of the blackbox tie-off sources: consumes a bus of constant or spare nets and monitors it.
- Synchronizes the bus and records any deviation from the expected tie value. Deviations appear as sticky per-bit change flags, a saturating event counter and a mismatch flag.
- Status is readable through a valid/ready request/response port.
- Sits beside the tie-off cells inside partition top levels and feeds debug/status logic.

Parameters:
- WIDTH, 8, number of monitored nets; legal range 1..32.
- EXPECT, {WIDTH{1'b0}}, expected constant value of the monitored bus.
- CNT_W, 16, width of the change-event counter; legal range 1..32.

Ports:
- nvdla_core_clk  in  1  core clock.
- nvdla_core_rst  in  1  reset, asynchronous assert, active-high.
- snk_in  in  WIDTH  monitored nets; may be asynchronous to the clock.
- mon_en  in  1  enables updates to the status registers.
- clr  in  1  single-cycle clear of the sticky mask, the counter and mismatch.
- rd_req_pvld  in  1  read request valid.
- rd_req_prdy  out  1  read request ready.
- rd_req_addr  in  2  register select.
- rd_rsp_pvld  out  1  response valid.
- rd_rsp_prdy  in  1  response ready.
- rd_rsp_data  out  32  response data.
- mismatch  out  1  sticky flag: the synchronized bus differed from EXPECT.

Behaviour:
- Reset values:
  - Sync stages s1, s2 and history stage s3 reset to EXPECT, so no spurious change event follows reset.
  - Sticky mask = 0, cnt = 0, mismatch = 0.
  - rd_req_prdy = 1, rd_rsp_pvld = 0, rd_rsp_data = 0.
  - FSM in IDLE.
- Pipeline: s1 <= snk_in, s2 <= s1, s3 <= s2 on every clock, regardless of mon_en.
- Event definition: chg = s2 ^ s3; evt = |chg.
- Updates, active only while mon_en = 1:
  - sticky <= (clr ? 0 : sticky) | chg.
  - cnt <= (clr ? 0 : cnt) + evt, saturating at 2^CNT_W-1.
  - mismatch <= (clr ? 0 : mismatch) | (s2 != EXPECT).
- Clear/event precedence: when clr and an event occur in the same cycle, the clear applies first and the event is then recorded.
- mon_en = 0: status registers hold their values; clr is still honoured.
- Latency: snk_in stable before rising edge k -> sticky, cnt and mismatch updated at edge k+2.
- Register map, all fields zero-extended to 32 bits:
  - addr 0: s2 (current synchronized value).
  - addr 1: sticky mask.
  - addr 2: cnt.
  - addr 3: {31'b0, mismatch}.
- FSM, 2 states:
  - IDLE: rd_req_prdy = 1. When rd_req_pvld = 1, the request is accepted; the selected register is snapshotted into rd_rsp_data on the same edge and the FSM moves to RESP.
  - RESP: rd_req_prdy = 0 and rd_rsp_pvld = 1. rd_rsp_data holds stable until rd_rsp_prdy = 1, then the FSM returns to IDLE.
- Response timing:
  - Accept-to-response latency is 1 cycle.
  - Maximum throughput is one read per 2 cycles; a new request is not accepted in the same cycle as the response handshake.
- Read coinciding with clr: the response returns the pre-clear value because the snapshot is taken at accept.
- Response stall: a stalled response (rd_rsp_prdy = 0) holds indefinitely. Monitoring continues during the stall; the held data is not refreshed.
- Reset asserted mid-transaction: FSM returns to IDLE, the in-flight response is dropped and rd_rsp_pvld = 0 immediately.
- Output timing: all outputs are registered except rd_req_prdy, which is decoded from the FSM state.

Decomposition:
- Shared package nv_blkbox_pkg holds:
  - Register address constants: ADDR_CUR = 0, ADDR_STICKY = 1, ADDR_CNT = 2, ADDR_MISM = 3.
  - The FSM state typedef {IDLE, RESP}.
- One sub-module: nv_blkbox_sync2, a WIDTH-wide 2-flop synchronizer with parameterized reset value, instantiated once.

Test Plan:
- Reset, snk_in = 0x00 held: reads of addr 0..3 each return 0x0; rd_rsp_pvld rises exactly 1 cycle after each accept.
- snk_in pulses to 0x05 for 4 cycles, then returns to 0x00 (mon_en = 1): sticky = 0x05, cnt = 2, mismatch = 1; sticky updates at edge k+2.
- CNT_W = 2, 5 toggles of bit 0: cnt saturates at 3.
- clr in the same cycle as a read accept of addr 2 with cnt = 2: response = 2; a subsequent read returns 0.
- rd_rsp_prdy held low 10 cycles while snk_in toggles: rd_rsp_data stable, rd_req_prdy = 0 throughout; the counter keeps advancing, confirmed by the next read.
- Reset asserted while in RESP: rd_rsp_pvld = 0 at once; after deassert, rd_req_prdy = 1 and all status reads return 0.

Source files
------------

// File: rtl/nv_blkbox_pkg.sv
// Shared definitions for the blackbox sink monitor: register map and read FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package nv_blkbox_pkg;

    // Status register selects on the read port
    localparam logic [1:0] ADDR_CUR    = 2'd0;
    localparam logic [1:0] ADDR_STICKY = 2'd1;
    localparam logic [1:0] ADDR_CNT    = 2'd2;
    localparam logic [1:0] ADDR_MISM   = 2'd3;

    // Read port FSM: waiting for a request, or holding a response
    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } rd_state_e;

endpackage

// File: rtl/nv_blkbox_sync2.sv
// WIDTH-wide two-flop synchronizer with a configurable reset value.
// Latency: 2 cycles from i_d to o_q.
// Backpressure: none; samples every clock.
module nv_blkbox_sync2 #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;

    // Two back-to-back flops; resetting to the expected tie value keeps
    // the first post-reset cycles free of artificial transitions
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1 <= RST_VAL;
            r_s2 <= RST_VAL;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/nv_blkbox_sink_mon.sv
// Monitors a bus of tie-off nets: sticky change mask, saturating event counter, mismatch flag.
// Latency: snk_in to status 2 edges after capture; read accept to response 1 cycle.
// Backpressure: one read outstanding; the response holds until rd_rsp_prdy, requests are refused meanwhile.
module nv_blkbox_sink_mon
    import nv_blkbox_pkg::*;
#(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] EXPECT = {WIDTH{1'b0}},
    parameter int               CNT_W  = 16
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rst,
    input  logic [WIDTH-1:0] snk_in,
    input  logic             mon_en,
    input  logic             clr,
    input  logic             rd_req_pvld,
    output logic             rd_req_prdy,
    input  logic [1:0]       rd_req_addr,
    output logic             rd_rsp_pvld,
    input  logic             rd_rsp_prdy,
    output logic [31:0]      rd_rsp_data,
    output logic             mismatch
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] w_s2;
    logic [WIDTH-1:0] r_s3;
    logic [WIDTH-1:0] w_chg;
    logic             w_evt;
    logic [WIDTH-1:0] r_sticky;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_base;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_mismatch;
    logic [31:0]      w_rd_dat;
    rd_state_e        r_state;
    rd_state_e        w_state_nxt;
    logic             w_req_prdy;
    logic             w_accept;
    logic             r_rsp_pvld;
    logic [31:0]      r_rsp_data;

    nv_blkbox_sync2 #(
        .WIDTH   (WIDTH),
        .RST_VAL (EXPECT)
    ) u_sync (
        .i_clk (nvdla_core_clk),
        .i_rst (nvdla_core_rst),
        .i_d   (snk_in),
        .o_q   (w_s2)
    );

    // History stage: previous synchronized value, used only for edge detection
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) r_s3 <= EXPECT;
        else                r_s3 <= w_s2;
    end

    assign w_chg = w_s2 ^ r_s3;
    assign w_evt = |w_chg;

    // Clear takes effect first, then this cycle's event is counted, saturating at all-ones
    always_comb begin
        w_cnt_base = clr ? '0 : r_cnt;
        w_cnt_nxt  = w_cnt_base;
        if (w_evt && (w_cnt_base != CNT_MAX)) w_cnt_nxt = w_cnt_base + CNT_W'(1);
    end

    // Status registers: accumulate while enabled; a clear is honoured even when disabled
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            r_sticky   <= '0;
            r_cnt      <= '0;
            r_mismatch <= 1'b0;
        end else if (mon_en) begin
            r_sticky   <= (clr ? '0 : r_sticky) | w_chg;
            r_cnt      <= w_cnt_nxt;
            r_mismatch <= (clr ? 1'b0 : r_mismatch) | (w_s2 != EXPECT);
        end else if (clr) begin
            r_sticky   <= '0;
            r_cnt      <= '0;
            r_mismatch <= 1'b0;
        end
    end

    // Register map mux, every field zero-extended to the 32-bit response
    always_comb begin
        w_rd_dat = '0;
        case (rd_req_addr)
            ADDR_CUR:    w_rd_dat[WIDTH-1:0] = w_s2;
            ADDR_STICKY: w_rd_dat[WIDTH-1:0] = r_sticky;
            ADDR_CNT:    w_rd_dat[CNT_W-1:0] = r_cnt;
            ADDR_MISM:   w_rd_dat[0]         = r_mismatch;
            default:     w_rd_dat            = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) r_state <= IDLE;
        else                r_state <= w_state_nxt;
    end

    // FSM next state: accept in IDLE, leave RESP on the response handshake
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (rd_req_pvld) w_state_nxt = RESP;
            RESP:    if (rd_rsp_prdy) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs: ready only in IDLE, so no accept in the response handshake cycle
    always_comb begin
        w_req_prdy = (r_state == IDLE);
        w_accept   = w_req_prdy & rd_req_pvld;
    end

    // Response registers: snapshot taken at accept, so a coincident clear reads the old value
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            r_rsp_pvld <= 1'b0;
            r_rsp_data <= '0;
        end else begin
            r_rsp_pvld <= (w_state_nxt == RESP);
            if (w_accept) r_rsp_data <= w_rd_dat;
        end
    end

    assign rd_req_prdy = w_req_prdy;
    assign rd_rsp_pvld = r_rsp_pvld;
    assign rd_rsp_data = r_rsp_data;
    assign mismatch    = r_mismatch;

endmodule

// File: tb/tb_nv_blkbox_sink_mon.sv
// Bench for nv_blkbox_sink_mon: two instances (16-bit and 2-bit counters) share one stimulus stream.
// A history-based reference model pushes expected read responses into a scoreboard at accept;
// a negedge monitor pops and compares them and checks handshake and mismatch each cycle.
module tb_nv_blkbox_sink_mon;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  snk_in = 8'h00;
    logic        mon_en = 1'b1;
    logic        clr = 1'b0;
    logic        rd_req_pvld = 1'b0;
    logic [1:0]  rd_req_addr = 2'd0;
    logic        rd_rsp_prdy = 1'b1;

    logic        req_prdy_a, rsp_pvld_a, mism_a;
    logic        req_prdy_b, rsp_pvld_b, mism_b;
    logic [31:0] rsp_data_a, rsp_data_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nv_blkbox_sink_mon #(.WIDTH(8), .EXPECT(8'h00), .CNT_W(16)) dut_a (
        .nvdla_core_clk (clk),        .nvdla_core_rst (rst),
        .snk_in         (snk_in),     .mon_en         (mon_en),
        .clr            (clr),        .rd_req_pvld    (rd_req_pvld),
        .rd_req_prdy    (req_prdy_a), .rd_req_addr    (rd_req_addr),
        .rd_rsp_pvld    (rsp_pvld_a), .rd_rsp_prdy    (rd_rsp_prdy),
        .rd_rsp_data    (rsp_data_a), .mismatch       (mism_a)
    );

    nv_blkbox_sink_mon #(.WIDTH(8), .EXPECT(8'h00), .CNT_W(2)) dut_b (
        .nvdla_core_clk (clk),        .nvdla_core_rst (rst),
        .snk_in         (snk_in),     .mon_en         (mon_en),
        .clr            (clr),        .rd_req_pvld    (rd_req_pvld),
        .rd_req_prdy    (req_prdy_b), .rd_req_addr    (rd_req_addr),
        .rd_rsp_pvld    (rsp_pvld_b), .rd_rsp_prdy    (rd_rsp_prdy),
        .rd_rsp_data    (rsp_data_b), .mismatch       (mism_b)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [1:0]  addr;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] samp[$];          // input values captured at past edges, oldest first
    logic [7:0] m_sticky = 8'h00;
    int         m_cnt_a  = 0;
    int         m_cnt_b  = 0;
    logic       m_mism   = 1'b0;
    logic       m_resp   = 1'b0;
    int         n_acc    = 0;

    // Pre-edge view of a register: the visible bus value is the input captured two edges ago
    function automatic logic [31:0] reg_val(input logic [1:0] ad, input int cnt);
        case (ad)
            2'd0:    return {24'h0, samp[samp.size()-2]};
            2'd1:    return {24'h0, m_sticky};
            2'd2:    return cnt;
            default: return {31'h0, m_mism};
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin : model
        logic [7:0] cur;
        logic [7:0] prev;
        if (rst) begin
            m_sticky = 8'h00; m_cnt_a = 0; m_cnt_b = 0; m_mism = 1'b0; m_resp = 1'b0;
            samp.delete();
            repeat (3) samp.push_back(8'h00);
            sbq.delete();
        end else begin
            cur  = samp[samp.size()-2];
            prev = samp[samp.size()-3];
            if (!m_resp) begin
                if (rd_req_pvld) begin
                    sbq.push_back('{rd_req_addr, reg_val(rd_req_addr, m_cnt_a), reg_val(rd_req_addr, m_cnt_b)});
                    m_resp = 1'b1;
                    n_acc++;
                end
            end else if (rd_rsp_prdy) begin
                m_resp = 1'b0;
            end
            if (clr) begin
                m_sticky = 8'h00; m_cnt_a = 0; m_cnt_b = 0; m_mism = 1'b0;
            end
            if (mon_en) begin
                m_sticky |= cur ^ prev;
                if (cur != prev) begin
                    if (m_cnt_a < 65535) m_cnt_a++;
                    if (m_cnt_b < 3)     m_cnt_b++;
                end
                if (cur != 8'h00) m_mism = 1'b1;
            end
            samp.push_back(snk_in);
            void'(samp.pop_front());
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        chk("req_prdy_a", {31'h0, req_prdy_a}, {31'h0, !m_resp});
        chk("req_prdy_b", {31'h0, req_prdy_b}, {31'h0, !m_resp});
        chk("rsp_pvld_a", {31'h0, rsp_pvld_a}, {31'h0, m_resp});
        chk("rsp_pvld_b", {31'h0, rsp_pvld_b}, {31'h0, m_resp});
        chk("mismatch_a", {31'h0, mism_a}, {31'h0, m_mism});
        chk("mismatch_b", {31'h0, mism_b}, {31'h0, m_mism});
        if (rsp_pvld_a || rsp_pvld_b) begin
            if (sbq.size() == 0) begin
                total++; bad++;
                $display("FAIL rsp_unexpected actual=valid required=no response t=%0t", $time);
            end else begin
                chk($sformatf("rsp_data_a[addr%0d]", sbq[0].addr), rsp_data_a, sbq[0].a);
                chk($sformatf("rsp_data_b[addr%0d]", sbq[0].addr), rsp_data_b, sbq[0].b);
                if (rd_rsp_prdy) void'(sbq.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && m_resp; i++) step(1);
        if (m_resp) begin
            total++; bad++;
            $display("FAIL drain_timeout actual=busy required=idle t=%0t", $time);
        end
    endtask

    // Issue one read; with_clr pulses clr on the accept cycle
    task automatic rd(input logic [1:0] a, input bit with_clr);
        int n0;
        n0 = n_acc;
        rd_req_pvld = 1'b1;
        rd_req_addr = a;
        if (with_clr) clr = 1'b1;
        for (int i = 0; i < 20 && n_acc == n0; i++) begin
            step(1);
            clr = 1'b0;
        end
        rd_req_pvld = 1'b0;
        if (n_acc == n0) begin
            total++; bad++;
            $display("FAIL accept_timeout actual=none required=accept t=%0t", $time);
        end
        if (rd_rsp_prdy) wait_idle();
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        step(2);

        // After reset with the bus at the tie value, all registers read zero
        for (int a = 0; a < 4; a++) rd(2'(a), 1'b0);

        // 4-cycle pulse of 0x05: two transitions, bits 0 and 2 sticky, mismatch set
        snk_in = 8'h05; step(4);
        snk_in = 8'h00; step(5);
        for (int a = 0; a < 4; a++) rd(2'(a), 1'b0);

        // Five toggles of bit 0 after a clear: narrow counter stops at 3
        clr = 1'b1; step(1); clr = 1'b0;
        for (int i = 0; i < 5; i++) begin snk_in ^= 8'h01; step(3); end
        step(4);
        rd(2'd2, 1'b0);
        rd(2'd1, 1'b0);

        // Read coinciding with clear returns the old count; the next read sees zero
        clr = 1'b1; step(1); clr = 1'b0;
        snk_in = 8'h10; step(4);
        snk_in = 8'h00; step(5);
        rd(2'd2, 1'b1);
        step(2);
        rd(2'd2, 1'b0);

        // Stalled response: data must hold while monitoring continues
        rd_rsp_prdy = 1'b0;
        rd(2'd2, 1'b0);
        for (int i = 0; i < 10; i++) begin snk_in ^= 8'h80; step(1); end
        snk_in = 8'h00;
        rd_rsp_prdy = 1'b1;
        wait_idle();
        step(4);
        rd(2'd2, 1'b0);

        // Randomised traffic on every input
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) snk_in = 8'($urandom);
            mon_en      = ($urandom_range(0, 9) < 8);
            clr         = ($urandom_range(0, 29) == 0);
            rd_req_pvld = $urandom_range(0, 1);
            rd_req_addr = 2'($urandom_range(0, 3));
            rd_rsp_prdy = ($urandom_range(0, 9) < 7);
            step(1);
        end
        rd_req_pvld = 1'b0; clr = 1'b0; mon_en = 1'b1; rd_rsp_prdy = 1'b1; snk_in = 8'h00;
        wait_idle();
        step(5);

        // Reset while a response is held: valid drops at once, status reads zero afterwards
        rd_rsp_prdy = 1'b0;
        rd(2'd1, 1'b0);
        step(2);
        #2 rst = 1'b1;
        #1;
        chk("rst_pvld_a", {31'h0, rsp_pvld_a}, 32'h0);
        chk("rst_pvld_b", {31'h0, rsp_pvld_b}, 32'h0);
        chk("rst_prdy_a", {31'h0, req_prdy_a}, 32'h1);
        step(2);
        rst = 1'b0;
        rd_rsp_prdy = 1'b1;
        step(2);
        for (int a = 0; a < 4; a++) rd(2'(a), 1'b0);

        step(3);
        chk("scoreboard_empty", sbq.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
